// File: rtl/alu_rf_sequencer.sv
// Instruction sequencer for the 8-bit ALU / 8x8 register-file datapath.
// Queues 16-bit instructions in a small FIFO and runs each one as a fixed
// multi-cycle sequence on the datapath: LDI, EXEC [+ WB], DONE.
module alu_rf_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [2:0]  dp_opcode,
  output logic [7:0]  dp_data_in,
  output logic [2:0]  dp_rd_addr1,
  output logic [2:0]  dp_rd_addr2,
  output logic [2:0]  dp_wr_addr,
  output logic        dp_wr_en,
  output logic        dp_c_in,
  input  logic [8:0]  dp_alu_out,
  output logic [7:0]  result,
  output logic        carry_flag,
  output logic        done,
  output logic        busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDI  = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  logic [15:0]      fifo_mem [FIFO_DEPTH];
  logic [15:0]      fifo_head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q;
  logic             push;
  logic             pop;

  state_e           state_q, state_d;
  logic [15:0]      instr_q, instr_d;
  logic [7:0]       result_q, result_d;
  logic             carry_q, carry_d;
  logic             done_q;
  logic             busy_q;
  logic             wr_en_c;
  logic             c_in_c;

  assign push      = instr_valid & ready_q;
  assign fifo_head = fifo_mem[rd_ptr_q];

  // FIFO storage; contents need no reset because the pointers do
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= instr_in;
    end
  end

  // FIFO pointer/count next state; power-of-two depth gives natural wrap
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Next-state, instruction latch and architectural result/carry updates
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    result_d = result_q;
    carry_d  = carry_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          instr_d = fifo_head;
          state_d = fifo_head[15] ? S_LDI : S_EXEC;
        end
      end
      S_LDI: begin
        result_d = instr_q[7:0];
        state_d  = S_DONE;
      end
      S_EXEC: begin
        result_d = dp_alu_out[7:0];
        carry_d  = dp_alu_out[8];
        state_d  = instr_q[1] ? S_DONE : S_WB;
      end
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath strobes depend only on registered state, never on dp_alu_out
  always_comb begin
    wr_en_c = 1'b0;
    c_in_c  = 1'b0;
    case (state_q)
      S_LDI:   wr_en_c = 1'b1;
      S_EXEC:  c_in_c  = instr_q[2] & carry_q;
      S_WB:    wr_en_c = 1'b1;
      default: begin
        wr_en_c = 1'b0;
        c_in_c  = 1'b0;
      end
    endcase
  end

  // State, FIFO bookkeeping and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      done_q   <= (state_d == S_DONE);
      busy_q   <= (state_d != S_IDLE) || (count_d != '0);
      ready_q  <= (count_d != CNT_W'(FIFO_DEPTH));
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Datapath fields come straight from the latched instruction; LDI and ALU
  // place dst at different bit positions
  assign dp_opcode   = instr_q[14:12];
  assign dp_rd_addr1 = instr_q[8:6];
  assign dp_rd_addr2 = instr_q[5:3];
  assign dp_wr_addr  = instr_q[15] ? instr_q[10:8] : instr_q[11:9];
  assign dp_data_in  = (state_q == S_WB) ? result_q : instr_q[7:0];
  // Reset suppresses an in-flight register write in the same cycle
  assign dp_wr_en    = wr_en_c & rst_n;
  assign dp_c_in     = c_in_c;

  assign instr_ready = ready_q;
  assign result      = result_q;
  assign carry_flag  = carry_q;
  assign done        = done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_alu_rf_sequencer.sv
// Bench for alu_rf_sequencer: behavioural register file + ALU on the dp_*
// port, table of single instructions, FIFO fill/wrap run and mid-op reset.
module tb_alu_rf_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  dp_opcode;
  logic [7:0]  dp_data_in;
  logic [2:0]  dp_rd_addr1;
  logic [2:0]  dp_rd_addr2;
  logic [2:0]  dp_wr_addr;
  logic        dp_wr_en;
  logic        dp_c_in;
  logic [8:0]  dp_alu_out;
  logic [7:0]  result;
  logic        carry_flag;
  logic        done;
  logic        busy;

  alu_rf_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .dp_opcode   (dp_opcode),
    .dp_data_in  (dp_data_in),
    .dp_rd_addr1 (dp_rd_addr1),
    .dp_rd_addr2 (dp_rd_addr2),
    .dp_wr_addr  (dp_wr_addr),
    .dp_wr_en    (dp_wr_en),
    .dp_c_in     (dp_c_in),
    .dp_alu_out  (dp_alu_out),
    .result      (result),
    .carry_flag  (carry_flag),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Datapath model: opcode 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, else pass a
  logic [7:0] rf [8];
  logic [7:0] op_a, op_b;

  always @(posedge clk) begin
    if (dp_wr_en) rf[dp_wr_addr] <= dp_data_in;
  end

  always_comb begin
    op_a = rf[dp_rd_addr1];
    op_b = rf[dp_rd_addr2];
    case (dp_opcode)
      3'd0:    dp_alu_out = 9'(op_a) + 9'(op_b) + 9'(dp_c_in);
      3'd1:    dp_alu_out = 9'(op_a) - 9'(op_b) - 9'(dp_c_in);
      3'd2:    dp_alu_out = {1'b0, op_a & op_b};
      3'd3:    dp_alu_out = {1'b0, op_a | op_b};
      3'd4:    dp_alu_out = {1'b0, op_a ^ op_b};
      default: dp_alu_out = {1'b0, op_a};
    endcase
  end

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  res;
    logic        c;
    int          lat;
    int          wr;
    logic [8:0]  alu;
    logic        cin;
  } vec_t;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
  } sb_t;

  sb_t        sb_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         done_cnt = 0;
  logic [7:0] exp_rf [8];
  logic       cur_carry = 1'b0;
  vec_t       tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ldi(input logic [2:0] dst, input logic [7:0] imm);
    return {1'b1, 4'b0000, dst, imm};
  endfunction

  function automatic logic [15:0] alu(input logic [2:0] op, input logic [2:0] dst,
                                      input logic [2:0] s1, input logic [2:0] s2,
                                      input logic uc, input logic nw);
    return {1'b0, op, dst, s1, s2, uc, nw, 1'b0};
  endfunction

  function automatic vec_t mk(input logic [15:0] w, input logic [7:0] r, input logic c,
                              input int lat, input int wr, input logic [8:0] a, input logic ci);
    vec_t v;
    v.instr = w; v.res = r; v.c = c; v.lat = lat; v.wr = wr; v.alu = a; v.cin = ci;
    return v;
  endfunction

  // Scoreboard: every done pulse retires the oldest expected result
  always @(negedge clk) begin
    sb_t e;
    if (rst_n && done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done result=0x%0h", result);
      end else begin
        e = sb_q.pop_front();
        check("sb_result", 32'(result), 32'(e.res));
        check("sb_carry", 32'(carry_flag), 32'(e.c));
      end
    end
  end

  task automatic send(input logic [15:0] w, input logic [7:0] r, input logic c);
    sb_t e;
    @(negedge clk);
    instr_in    = w;
    instr_valid = 1'b1;
    e.res = r;
    e.c   = c;
    sb_q.push_back(e);
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  // One instruction from an idle, empty sequencer; k counts cycles after push
  task automatic run_vec(input vec_t v);
    int         done_at;
    int         wr_n;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [8:0] alu_s;
    logic       cin_s;
    logic [2:0] dst;
    dst     = v.instr[15] ? v.instr[10:8] : v.instr[11:9];
    done_at = -1;
    wr_n    = 0;
    wa      = '0;
    wd      = '0;
    alu_s   = '0;
    cin_s   = 1'b0;
    send(v.instr, v.res, v.c);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        alu_s = dp_alu_out;
        cin_s = dp_c_in;
      end
      if (dp_wr_en) begin
        wr_n++;
        wa = dp_wr_addr;
        wd = dp_data_in;
      end
      if (done && done_at < 0) done_at = k;
    end
    check("done_latency", 32'(done_at), 32'(v.lat));
    check("write_pulses", 32'(wr_n), 32'(v.wr));
    if (v.wr > 0) begin
      check("write_addr", 32'(wa), 32'(dst));
      check("write_data", 32'(wd), 32'(v.res));
      exp_rf[dst] = v.res;
    end
    if (!v.instr[15]) begin
      check("exec_alu_out", 32'(alu_s), 32'(v.alu));
      check("exec_c_in", 32'(cin_s), 32'(v.cin));
    end
    cur_carry = v.c;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int         k;
    int         guard;
    int         first_drop;
    int         pre_done;
    logic [7:0] imm;
    sb_t        e;

    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_in    = '0;
    for (int i = 0; i < 8; i++) exp_rf[i] = '0;

    tbl[0] = mk(ldi(3'd1, 8'h80),                   8'h80, 1'b0, 2, 1, 9'h000, 1'b0);
    tbl[1] = mk(ldi(3'd2, 8'h80),                   8'h80, 1'b0, 2, 1, 9'h000, 1'b0);
    tbl[2] = mk(alu(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0), 8'h00, 1'b1, 3, 1, 9'h100, 1'b0);
    tbl[3] = mk(ldi(3'd4, 8'h01),                   8'h01, 1'b1, 2, 1, 9'h000, 1'b0);
    tbl[4] = mk(ldi(3'd5, 8'h01),                   8'h01, 1'b1, 2, 1, 9'h000, 1'b0);
    tbl[5] = mk(alu(3'd0, 3'd6, 3'd4, 3'd5, 1'b1, 1'b0), 8'h03, 1'b0, 3, 1, 9'h003, 1'b1);
    tbl[6] = mk(ldi(3'd2, 8'h01),                   8'h01, 1'b0, 2, 1, 9'h000, 1'b0);
    tbl[7] = mk(alu(3'd3, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1), 8'h81, 1'b0, 2, 0, 9'h081, 1'b0);
    tbl[8] = mk(alu(3'd0, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0), 8'h00, 1'b1, 3, 1, 9'h100, 1'b0);
    tbl[9] = mk(alu(3'd0, 3'd2, 3'd2, 3'd1, 1'b1, 1'b0), 8'h02, 1'b0, 3, 1, 9'h002, 1'b1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", 32'(result), 32'h0);
    check("rst_carry", 32'(carry_flag), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_wr_en", 32'(dp_wr_en), 32'h0);
    check("rst_ready", 32'(instr_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_dp_data", 32'(dp_data_in), 32'h0);
    check("rst_dp_wr_addr", 32'(dp_wr_addr), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("idle_busy", 32'(busy), 32'h0);

    // Table of isolated instructions
    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i]);
      if (i == 2) check("three_dones", 32'(done_cnt), 32'd3);
    end
    check("rf3_after_add", 32'(rf[3]), 32'h00);
    check("rf6_after_chain", 32'(rf[6]), 32'h03);
    check("rf0_no_wb", 32'(rf[0]), 32'h00);

    // FIFO fill and wrap: hold valid with 10 LDIs back to back
    pre_done   = done_cnt;
    k          = 0;
    guard      = 0;
    first_drop = -1;
    while (k < 10 && guard < 300) begin
      @(negedge clk);
      guard++;
      imm         = 8'(8'hA0 + k);
      instr_in    = ldi(3'(k), imm);
      instr_valid = 1'b1;
      if (instr_ready) begin
        e.res = imm;
        e.c   = cur_carry;
        sb_q.push_back(e);
        exp_rf[3'(k)] = imm;
        k++;
      end else if (first_drop < 0) begin
        first_drop = k;
      end
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    check("fill_accepted", 32'(k), 32'd10);
    // six pushes land before ready falls: two popped, four queued
    check("ready_drop_at", 32'(first_drop), 32'd6);
    guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    check("fill_drain_in_time", 32'(sb_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("fill_done_count", 32'(done_cnt - pre_done), 32'd10);
    check("fill_busy", 32'(busy), 32'h0);
    check("fill_ready", 32'(instr_ready), 32'h1);
    for (int i = 0; i < 8; i++) check($sformatf("fill_rf%0d", i), 32'(rf[i]), 32'(exp_rf[i]));

    // Reset during the WB cycle of an ADD with two LDIs queued behind it
    run_vec(mk(ldi(3'd1, 8'hC0), 8'hC0, cur_carry, 2, 1, 9'h000, 1'b0));
    pre_done = done_cnt;
    @(negedge clk);
    instr_in    = alu(3'd0, 3'd3, 3'd1, 3'd1, 1'b0, 1'b0);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_in = ldi(3'd5, 8'h55);
    @(posedge clk);
    #1 instr_in = ldi(3'd6, 8'h66);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    rst_n       = 1'b0;
    check("pre_rst_carry", 32'(carry_flag), 32'h1);
    check("pre_rst_result", 32'(result), 32'h80);
    @(negedge clk);
    check("rst_wb_wr_en", 32'(dp_wr_en), 32'h0);
    check("rst_wb_done", 32'(done), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("post_rst_carry", 32'(carry_flag), 32'h0);
    check("post_rst_result", 32'(result), 32'h0);
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_ready", 32'(instr_ready), 32'h1);
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_no_done", 32'(done_cnt - pre_done), 32'd0);
    check("post_rst_idle", 32'(busy), 32'h0);
    check("rst_rf3_kept", 32'(rf[3]), 32'(exp_rf[3]));
    check("rst_rf5_kept", 32'(rf[5]), 32'(exp_rf[5]));
    check("rst_rf6_kept", 32'(rf[6]), 32'(exp_rf[6]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
